// File: rtl/sr_cmd_conditioner.sv
// Conditions raw asynchronous set/clear requests into clean, mutually exclusive
// S/R command pulses separated by a settle gap, flagging simultaneous requests.
module sr_cmd_conditioner #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int PULSE_LEN       = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic set_req,
  input  logic clr_req,
  output logic S,
  output logic R,
  output logic busy,
  output logic conflict
);

  localparam logic [7:0] CNT_LAST   = 8'(DEBOUNCE_CYCLES - 1);
  localparam logic [3:0] PULSE_LAST = 4'(PULSE_LEN - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DRIVE_S = 2'd1,
    DRIVE_R = 2'd2,
    GAP     = 2'd3
  } state_t;

  state_t     state, state_next;
  logic [1:0] raw, s1, s2, deb, deb_d, ev;
  logic [7:0] cnt [2];
  logic       pend_s, pend_r, pend_s_next, pend_r_next;
  logic [3:0] pcnt, pcnt_next;
  logic       s_next, r_next, conflict_next;
  logic       want_s, want_r;

  // Bit 0 carries the set path, bit 1 the clear path.
  assign raw = {clr_req, set_req};
  assign ev  = deb & ~deb_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1    <= '0;
      s2    <= '0;
      deb   <= '0;
      deb_d <= '0;
      for (int i = 0; i < 2; i++) cnt[i] <= '0;
    end else begin
      s1    <= raw;
      s2    <= s1;
      deb_d <= deb;
      for (int i = 0; i < 2; i++) begin
        // Any return of s2 to the accepted level restarts the stability count.
        if (s2[i] == deb[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_LAST) begin
          deb[i] <= s2[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + 8'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      pcnt     <= '0;
      pend_s   <= 1'b0;
      pend_r   <= 1'b0;
      S        <= 1'b0;
      R        <= 1'b0;
      conflict <= 1'b0;
    end else begin
      state    <= state_next;
      pcnt     <= pcnt_next;
      pend_s   <= pend_s_next;
      pend_r   <= pend_r_next;
      S        <= s_next;
      R        <= r_next;
      conflict <= conflict_next;
    end
  end

  always_comb begin
    state_next    = state;
    pcnt_next     = pcnt;
    pend_s_next   = pend_s;
    pend_r_next   = pend_r;
    s_next        = 1'b0;
    r_next        = 1'b0;
    conflict_next = 1'b0;
    want_s        = ev[0] | pend_s;
    want_r        = ev[1] | pend_r;

    // Requests arriving mid-command are held (one deep) for the next IDLE cycle.
    if (state != IDLE) begin
      pend_s_next = pend_s | ev[0];
      pend_r_next = pend_r | ev[1];
    end

    case (state)
      IDLE: begin
        if (want_s && want_r) begin
          conflict_next = 1'b1;
          pend_s_next   = 1'b0;
          pend_r_next   = 1'b0;
        end else if (want_s) begin
          pend_s_next = 1'b0;
          s_next      = 1'b1;
          pcnt_next   = '0;
          state_next  = DRIVE_S;
        end else if (want_r) begin
          pend_r_next = 1'b0;
          r_next      = 1'b1;
          pcnt_next   = '0;
          state_next  = DRIVE_R;
        end
      end
      DRIVE_S: begin
        if (pcnt == PULSE_LAST) begin
          state_next = GAP;
        end else begin
          pcnt_next = pcnt + 4'd1;
          s_next    = 1'b1;
        end
      end
      DRIVE_R: begin
        if (pcnt == PULSE_LAST) begin
          state_next = GAP;
        end else begin
          pcnt_next = pcnt + 4'd1;
          r_next    = 1'b1;
        end
      end
      GAP: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_sr_cmd_conditioner.sv
// Directed bench for sr_cmd_conditioner (DEBOUNCE_CYCLES=4, PULSE_LEN=2).
// Outputs are compared as {S,R,busy,conflict} at the falling edge of each cycle.
module tb_sr_cmd_conditioner;

  logic clk;
  logic rst;
  logic set_req;
  logic clr_req;
  logic S;
  logic R;
  logic busy;
  logic conflict;

  int checks;
  int errors;

  sr_cmd_conditioner #(
    .DEBOUNCE_CYCLES(4),
    .PULSE_LEN      (2)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .set_req (set_req),
    .clr_req (clr_req),
    .S       (S),
    .R       (R),
    .busy    (busy),
    .conflict(conflict)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  // S and R must never be high together, in any cycle.
  always @(negedge clk) begin
    checks++;
    if (S && R) begin
      errors++;
      $display("FAIL exclusive: S=%0b R=%0b required not both 1 at %0t", S, R, $time);
    end
  end

  // One clock: advance past the rising edge and land on the falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_check(input string name, input int n);
    for (int i = 1; i <= n; i++) begin
      step();
      checks++;
      if ({S, R, busy, conflict} !== 4'b0000) begin
        errors++;
        $display("FAIL %s cyc %0d: SRbc=%b required 0000", name, i, {S, R, busy, conflict});
      end
    end
  endtask

  task automatic test_reset();
    logic [3:0] exp;
    rst     = 1'b1;
    set_req = 1'b1;
    clr_req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if ({S, R, busy, conflict} !== 4'b0000) begin
        errors++;
        $display("FAIL reset_hold %0d: SRbc=%b required 0000", i, {S, R, busy, conflict});
      end
    end
    rst = 1'b0;
    // set_req still high: the release looks like a fresh rising edge.
    for (int i = 1; i <= 14; i++) begin
      step();
      exp = {(i == 7 || i == 8), 1'b0, (i >= 7 && i <= 9), 1'b0};
      checks++;
      if ({S, R, busy, conflict} !== exp) begin
        errors++;
        $display("FAIL reset_release cyc %0d: SRbc=%b required %b", i, {S, R, busy, conflict}, exp);
      end
    end
    set_req = 1'b0;
    idle_check("reset_fall", 12);
  endtask

  task automatic test_clean_set();
    logic [3:0] exp;
    set_req = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      step();
      exp = {(i == 7 || i == 8), 1'b0, (i >= 7 && i <= 9), 1'b0};
      checks++;
      if ({S, R, busy, conflict} !== exp) begin
        errors++;
        $display("FAIL clean_set cyc %0d: SRbc=%b required %b", i, {S, R, busy, conflict}, exp);
      end
    end
    set_req = 1'b0;
    idle_check("clean_set_fall", 15);
  endtask

  task automatic test_clean_clr();
    logic [3:0] exp;
    clr_req = 1'b1;
    for (int i = 1; i <= 14; i++) begin
      step();
      exp = {1'b0, (i == 7 || i == 8), (i >= 7 && i <= 9), 1'b0};
      checks++;
      if ({S, R, busy, conflict} !== exp) begin
        errors++;
        $display("FAIL clean_clr cyc %0d: SRbc=%b required %b", i, {S, R, busy, conflict}, exp);
      end
    end
    clr_req = 1'b0;
    idle_check("clean_clr_fall", 12);
  endtask

  task automatic test_bounce();
    logic [3:0] exp;
    // Two-cycle bounces never hold long enough to be accepted.
    for (int i = 0; i < 12; i++) begin
      set_req = ((i / 2) % 2 == 0);
      step();
      checks++;
      if ({S, R, busy, conflict} !== 4'b0000) begin
        errors++;
        $display("FAIL bounce_toggle %0d: SRbc=%b required 0000", i, {S, R, busy, conflict});
      end
    end
    set_req = 1'b0;
    idle_check("bounce_hold0", 15);
    for (int i = 0; i < 12; i++) begin
      set_req = ((i / 2) % 2 == 0);
      step();
    end
    set_req = 1'b1;
    for (int i = 1; i <= 14; i++) begin
      step();
      exp = {(i == 7 || i == 8), 1'b0, (i >= 7 && i <= 9), 1'b0};
      checks++;
      if ({S, R, busy, conflict} !== exp) begin
        errors++;
        $display("FAIL bounce_hold1 cyc %0d: SRbc=%b required %b", i, {S, R, busy, conflict}, exp);
      end
    end
    set_req = 1'b0;
    idle_check("bounce_fall", 12);
  endtask

  task automatic test_conflict();
    logic [3:0] exp;
    set_req = 1'b1;
    clr_req = 1'b1;
    for (int i = 1; i <= 15; i++) begin
      step();
      exp = {3'b000, (i == 7)};
      checks++;
      if ({S, R, busy, conflict} !== exp) begin
        errors++;
        $display("FAIL conflict cyc %0d: SRbc=%b required %b", i, {S, R, busy, conflict}, exp);
      end
    end
    set_req = 1'b0;
    clr_req = 1'b0;
    idle_check("conflict_fall", 12);
  endtask

  task automatic test_back_to_back();
    logic [3:0] exp;
    // clr_req is first sampled 2 edges after set_req, so its event lands mid-pulse.
    set_req = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (i == 2) clr_req = 1'b1;
      exp = {(i == 7 || i == 8), (i == 11 || i == 12),
             ((i >= 7 && i <= 9) || (i >= 11 && i <= 13)), 1'b0};
      checks++;
      if ({S, R, busy, conflict} !== exp) begin
        errors++;
        $display("FAIL back_to_back cyc %0d: SRbc=%b required %b", i, {S, R, busy, conflict}, exp);
      end
    end
    set_req = 1'b0;
    clr_req = 1'b0;
    idle_check("back_to_back_fall", 12);
  endtask

  task automatic test_async_reset();
    set_req = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      step();
      if (i == 1) clr_req = 1'b1;
    end
    checks++;
    if (S !== 1'b1) begin
      errors++;
      $display("FAIL async_pre: S=%b required 1", S);
    end
    set_req = 1'b0;
    clr_req = 1'b0;
    #5;
    rst = 1'b1;
    #1;
    checks++;
    if ({S, R, busy, conflict} !== 4'b0000) begin
      errors++;
      $display("FAIL async_drop: SRbc=%b required 0000", {S, R, busy, conflict});
    end
    @(negedge clk);
    rst = 1'b0;
    // The pending clear was discarded; nothing may fire afterwards.
    idle_check("async_after", 20);
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    rst     = 1'b1;
    set_req = 1'b0;
    clr_req = 1'b0;
    test_reset();
    test_clean_set();
    test_clean_clr();
    test_bounce();
    test_conflict();
    test_back_to_back();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
